// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding, mode constants and one-hot helper
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest strobe vector the helper can produce (SEL_W up to 8).
  localparam int MAX_OUT_W = 256;

  // One-hot vector with bit idx set; all zero when idx falls outside width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx, input int unsigned width);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    if (idx < width && idx < MAX_OUT_W) v = MAX_OUT_W'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - dwell counter with clear and terminal-count flag
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tc
);

  logic [DWELL_W-1:0] count;

  // Count cycles spent on the current index; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + DWELL_W'(1);
    end
  end

  // Greater-or-equal so that lowering dwell below the running count ends
  // the current dwell at once instead of waiting for the counter to roll over.
  assign tc = (count >= dwell);

endmodule

// File: rtl/decoder_scan_nto2n.sv
// rtl/decoder_scan_nto2n.sv - N-to-2^N strobe decoder with DIRECT and SCAN modes
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int BLANK      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [SEL_W-1:0]      scan_limit,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   d_out,
  output logic [SEL_W-1:0]      d_idx,
  output logic                  active,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t           state, state_nxt;
  logic             tc;
  logic             cnt_clr, cnt_inc;
  logic             keep, accept;
  logic [SEL_W-1:0] adv_idx, pend_idx;
  logic             adv_wrap, pend_wrap;
  logic [OUT_W-1:0] d_out_nxt;
  logic [SEL_W-1:0] d_idx_nxt;
  logic             active_nxt, wrap_nxt;

  // Polarity is folded in here so the flop holds the final pin value.
  function automatic logic [OUT_W-1:0] strobe(input logic [SEL_W-1:0] i);
    return OUT_W'(onehot(32'(i), OUT_W)) ^ INACTIVE;
  endfunction

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .dwell (dwell),
    .tc    (tc)
  );

  assign sel_ready = (state == ST_DIRECT) && en;
  assign accept    = sel_valid && sel_ready;
  // Stay in the current mode only while enabled and mode still matches it.
  assign keep      = en && ((state == ST_DIRECT) ? (mode == MODE_DIRECT) : (mode == MODE_SCAN));
  assign adv_wrap  = (d_idx >= scan_limit);
  assign adv_idx   = adv_wrap ? '0 : d_idx + SEL_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision; any departure from a running mode goes via IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (en) state_nxt = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      ST_DIRECT: if (!keep) state_nxt = ST_IDLE;
      ST_SCAN: begin
        if (!keep)                    state_nxt = ST_IDLE;
        else if (tc && (BLANK != 0))  state_nxt = ST_GAP;
      end
      ST_GAP:    state_nxt = keep ? ST_SCAN : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next output values and counter control; default is a blank cycle.
  always_comb begin
    d_out_nxt  = INACTIVE;
    d_idx_nxt  = d_idx;
    active_nxt = 1'b0;
    wrap_nxt   = 1'b0;
    cnt_clr    = 1'b1;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && mode == MODE_SCAN) begin
          d_idx_nxt  = '0;
          d_out_nxt  = strobe('0);
          active_nxt = 1'b1;
        end
      end
      ST_DIRECT: begin
        if (keep) begin
          if (accept) begin
            d_idx_nxt  = sel;
            d_out_nxt  = strobe(sel);
            active_nxt = 1'b1;
          end else begin
            d_out_nxt  = d_out;
            active_nxt = active;
          end
        end
      end
      ST_SCAN: begin
        if (keep) begin
          if (!tc) begin
            cnt_clr    = 1'b0;
            cnt_inc    = 1'b1;
            d_out_nxt  = strobe(d_idx);
            active_nxt = 1'b1;
          end else if (BLANK == 0) begin
            d_idx_nxt  = adv_idx;
            d_out_nxt  = strobe(adv_idx);
            active_nxt = 1'b1;
            wrap_nxt   = adv_wrap;
          end
        end
      end
      ST_GAP: begin
        if (keep) begin
          d_idx_nxt  = pend_idx;
          d_out_nxt  = strobe(pend_idx);
          active_nxt = 1'b1;
          wrap_nxt   = pend_wrap;
        end
      end
      default: ;
    endcase
  end

  // Output registers, plus the advance held over a blanking gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out     <= INACTIVE;
      d_idx     <= '0;
      active    <= 1'b0;
      wrap      <= 1'b0;
      pend_idx  <= '0;
      pend_wrap <= 1'b0;
    end else begin
      d_out  <= d_out_nxt;
      d_idx  <= d_idx_nxt;
      active <= active_nxt;
      wrap   <= wrap_nxt;
      if (state == ST_SCAN && tc) begin
        pend_idx  <= adv_idx;
        pend_wrap <= adv_wrap;
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// tb/tb_decoder_scan_nto2n.sv - self-checking bench for decoder_scan_nto2n
module tb_decoder_scan_nto2n;

  logic       clk, rst_n, en, mode, sel_valid;
  logic [2:0] sel, scan_limit;
  logic [7:0] dwell;

  logic       sel_ready, active, wrap;
  logic [7:0] d_out;
  logic [2:0] d_idx;
  logic       b_ready, b_active, b_wrap;
  logic [7:0] b_out;
  logic [2:0] b_idx;
  logic       a_ready, a_active, a_wrap;
  logic [7:0] a_out;
  logic [2:0] a_idx;

  decoder_scan_nto2n dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(sel_ready), .scan_limit(scan_limit), .dwell(dwell),
    .d_out(d_out), .d_idx(d_idx), .active(active), .wrap(wrap)
  );

  decoder_scan_nto2n #(.BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(b_ready), .scan_limit(scan_limit), .dwell(dwell),
    .d_out(b_out), .d_idx(b_idx), .active(b_active), .wrap(b_wrap)
  );

  decoder_scan_nto2n #(.ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(a_ready), .scan_limit(scan_limit), .dwell(dwell),
    .d_out(a_out), .d_idx(a_idx), .active(a_active), .wrap(a_wrap)
  );

  typedef struct {
    logic       en, mode, sv;
    logic [2:0] sel, lim;
    logic [7:0] dw;
    logic       rdy;
    logic [7:0] dout;
    logic [2:0] idx;
    logic       act, wr;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic [2:0] idx;
    logic       act, wr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic add(input logic e, input logic m, input logic sv, input logic [2:0] s,
                     input logic [2:0] lim, input logic [7:0] dw, input logic rdy,
                     input logic [7:0] dout, input logic [2:0] idx, input logic act, input logic wr);
    vec_t v;
    v.en = e; v.mode = m; v.sv = sv; v.sel = s; v.lim = lim; v.dw = dw; v.rdy = rdy;
    v.dout = dout; v.idx = idx; v.act = act; v.wr = wr;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [7:0] dout, input logic [2:0] idx, input logic act, input logic wr);
    exp_t e;
    e.dout = dout; e.idx = idx; e.act = act; e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag, input logic [7:0] dout, input logic [2:0] idx,
                          input logic act, input logic wr);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " d_out"},  dout,       e.dout);
    chk({tag, " d_idx"},  8'(idx),    8'(e.idx));
    chk({tag, " active"}, 8'(act),    8'(e.act));
    chk({tag, " wrap"},   8'(wr),     8'(e.wr));
  endtask

  initial begin
    int p, ix;
    bit found;

    // DIRECT: accept 6 then 2 back to back, then hold.
    add(1,0,0,0,3,2, 0, 8'h00,0,0,0);
    add(1,0,1,6,3,2, 1, 8'h40,6,1,0);
    add(1,0,1,2,3,2, 1, 8'h04,2,1,0);
    add(1,0,0,0,3,2, 1, 8'h04,2,1,0);
    add(1,0,0,0,3,2, 1, 8'h04,2,1,0);
    // Switch to SCAN: blank via IDLE, then idx 0 with no wrap on entry.
    add(1,1,0,0,3,2, 1, 8'h00,2,0,0);
    add(1,1,0,0,3,2, 0, 8'h01,0,1,0);
    // SCAN limit 3 dwell 2: each strobe held 3 cycles, wrap on first 01 after 08.
    for (p = 1; p <= 15; p++) begin
      ix = (p / 3) % 4;
      add(1,1,0,0,3,2, 0, 8'(1 << ix), 3'(ix), 1, ((p % 3 == 0) && (ix == 0)) ? 1'b1 : 1'b0);
    end
    // dwell 0, limit 7: step to idx 5.
    add(1,1,0,0,7,0, 0, 8'h04,2,1,0);
    add(1,1,0,0,7,0, 0, 8'h08,3,1,0);
    add(1,1,0,0,7,0, 0, 8'h10,4,1,0);
    add(1,1,0,0,7,0, 0, 8'h20,5,1,0);
    // Limit lowered to 2 at idx 5: next advance wraps.
    add(1,1,0,0,2,0, 0, 8'h01,0,1,1);
    add(1,1,0,0,2,0, 0, 8'h02,1,1,0);
    add(1,1,0,0,2,0, 0, 8'h04,2,1,0);
    add(1,1,0,0,2,0, 0, 8'h01,0,1,1);
    // Limit 0, dwell 1: 01 held, wrap every 2 cycles.
    add(1,1,0,0,0,1, 0, 8'h01,0,1,0);
    add(1,1,0,0,0,1, 0, 8'h01,0,1,1);
    add(1,1,0,0,0,1, 0, 8'h01,0,1,0);
    add(1,1,0,0,0,1, 0, 8'h01,0,1,1);
    // en dropped for one cycle mid-scan: blank, idx held, restart at 0.
    add(1,1,0,0,3,0, 0, 8'h02,1,1,0);
    add(1,1,0,0,3,0, 0, 8'h04,2,1,0);
    add(0,1,0,0,3,0, 0, 8'h00,2,0,0);
    add(1,1,0,0,3,0, 0, 8'h01,0,1,0);
    add(1,1,0,0,3,0, 0, 8'h02,1,1,0);
    // SCAN -> DIRECT: blank through IDLE and until the first accept.
    add(1,0,1,5,3,0, 0, 8'h00,1,0,0);
    add(1,0,1,5,3,0, 0, 8'h00,1,0,0);
    add(1,0,0,5,3,0, 1, 8'h00,1,0,0);
    add(1,0,1,5,3,0, 1, 8'h20,5,1,0);
    add(0,0,0,0,3,0, 0, 8'h00,5,0,0);

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0;
    scan_limit = '0; dwell = '0;
    @(posedge clk); #1;
    chk("reset d_out", d_out, 8'h00);
    chk("reset d_idx", 8'(d_idx), 8'h00);
    chk("reset active", 8'(active), 8'h00);
    chk("reset wrap", 8'(wrap), 8'h00);
    chk("reset sel_ready", 8'(sel_ready), 8'h00);
    chk("reset al d_out", a_out, 8'hFF);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en; mode = vecs[i].mode; sel_valid = vecs[i].sv; sel = vecs[i].sel;
      scan_limit = vecs[i].lim; dwell = vecs[i].dw;
      #1;
      chk($sformatf("v%0d sel_ready", i), 8'(sel_ready), 8'(vecs[i].rdy));
      push_exp(vecs[i].dout, vecs[i].idx, vecs[i].act, vecs[i].wr);
      @(posedge clk); #1;
      sb_check($sformatf("v%0d", i), d_out, d_idx, active, wrap);
    end

    // Async reset mid-dwell at idx 5.
    en = 1'b1; mode = 1'b1; sel_valid = 1'b0; scan_limit = 3'd7; dwell = 8'd3;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge clk); #1;
      if (d_idx == 3'd5) found = 1;
    end
    chk("reach idx5", 8'(found), 8'h01);
    @(posedge clk); #1;
    chk("idx5 d_out", d_out, 8'h20);
    chk("idx5 al d_out", a_out, 8'hDF);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset d_out", d_out, 8'h00);
    chk("async reset active", 8'(active), 8'h00);
    chk("async reset al d_out", a_out, 8'hFF);
    chk("async reset al active", 8'(a_active), 8'h00);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BLANK instance: limit 1, dwell 0 -> 01,00,02,00,01(wrap),00,02.
    en = 1'b1; mode = 1'b1; scan_limit = 3'd1; dwell = 8'd0;
    push_exp(8'h01,0,1,0); push_exp(8'h00,0,0,0); push_exp(8'h02,1,1,0); push_exp(8'h00,1,0,0);
    push_exp(8'h01,0,1,1); push_exp(8'h00,0,0,0); push_exp(8'h02,1,1,0);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("blank%0d onehot", k), 8'($countones(b_out) <= 1), 8'h01);
      sb_check($sformatf("blank%0d", k), b_out, b_idx, b_active, b_wrap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
